mux21_feeder: RTL and testbench

- Two-channel bit-serial source directly upstream of the 2-1 selector (mux21); drives its S1, D0 and D1 inputs.
- Captures two W-bit words A and B on a START handshake.
- Shifts both words out MSB-first, toggling S1 so the selector's Y output carries the stream A[W-1], B[W-1], A[W-2], B[W-2], …, A[0], B[0].
- Replaces hand-written stimulus sequences with a reusable synchronous sequencer.

---
 rtl/mux21_feeder.sv | 83 ++++++++
 tb/tb_mux21_feeder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mux21_feeder.sv
// mux21_feeder: two-channel MSB-first serializer driving the S1/D0/D1 inputs of a 2-1 selector
module mux21_feeder #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         READY,
  output logic         S1,
  output logic         D0,
  output logic         D1,
  output logic         VALID,
  output logic         DONE
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sha_q, sha_d, shb_q, shb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, send_d;
  logic s1_q, d0_q, d1_q, valid_q, done_q;
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: if (START) begin
        sha_d   = A;
        shb_d   = B;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          sha_d   = sha_q << 1;
          shb_d   = shb_q << 1;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(W - 1)) ? FIN : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Output registers are loaded from the next state so they always match the state they describe
  assign send_d = (state_d == SEND);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      s1_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      s1_q    <= send_d & phase_d;
      d0_q    <= send_d & sha_d[W-1];
      d1_q    <= send_d & shb_d[W-1];
      valid_q <= send_d;
      done_q  <= (state_d == FIN);
    end
  end
  assign READY = (state_q == IDLE);
  assign S1    = s1_q;
  assign D0    = d0_q;
  assign D1    = d1_q;
  assign VALID = valid_q;
  assign DONE  = done_q;
endmodule

// File: tb/tb_mux21_feeder.sv
// tb_mux21_feeder: queue-based transfer model plus directed literal checks for W=4 and W=1
module tb_mux21_feeder;
  typedef struct packed {logic s1, d0, d1, valid, done, ready;} o_t;
  localparam o_t IDLE_O = 6'b000001;
  logic clk = 1'b0;
  logic rst;
  logic start = 1'b0, start1 = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic rdy, s1, d0, d1, vld, dn;
  logic rdy1, s1_1, d0_1, d1_1, vld1, dn1;
  int n_chk = 0, n_fail = 0;
  o_t q4[$], q1[$];
  o_t e4, e1;
  logic [7:0] ys, ss;
  logic [29:0] dmask;
  mux21_feeder #(.W(4)) dut4 (.CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
    .READY(rdy), .S1(s1), .D0(d0), .D1(d1), .VALID(vld), .DONE(dn));
  mux21_feeder #(.W(1)) dut1 (.CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1),
    .READY(rdy1), .S1(s1_1), .D0(d0_1), .D1(d1_1), .VALID(vld1), .DONE(dn1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [29:0] got, input logic [29:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask
  function automatic o_t out4();
    return {s1, d0, d1, vld, dn, rdy};
  endfunction
  function automatic o_t out1();
    return {s1_1, d0_1, d1_1, vld1, dn1, rdy1};
  endfunction
  // A transfer is 2W payload beats, one DONE beat, then one idle beat before the next accept
  always @(posedge clk) begin
    if (rst) begin
      q4.delete();
      q1.delete();
    end else begin
      if (q4.size() == 0 && start) begin
        for (int i = 3; i >= 0; i--) begin
          q4.push_back(o_t'({1'b0, a[i], b[i], 1'b1, 1'b0, 1'b0}));
          q4.push_back(o_t'({1'b1, a[i], b[i], 1'b1, 1'b0, 1'b0}));
        end
        q4.push_back(o_t'(6'b000010));
        q4.push_back(IDLE_O);
      end
      if (q1.size() == 0 && start1) begin
        q1.push_back(o_t'({1'b0, a1[0], b1[0], 1'b1, 1'b0, 1'b0}));
        q1.push_back(o_t'({1'b1, a1[0], b1[0], 1'b1, 1'b0, 1'b0}));
        q1.push_back(o_t'(6'b000010));
        q1.push_back(IDLE_O);
      end
    end
    e4 = (q4.size() > 0) ? q4.pop_front() : IDLE_O;
    e1 = (q1.size() > 0) ? q1.pop_front() : IDLE_O;
    #1;
    chk("model_w4", 30'(out4()), 30'(e4));
    chk("model_w1", 30'(out1()), 30'(e1));
  end
  task automatic run_s2(input string nm, input bit change_mid);
    a = 4'b1010;
    b = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ys = {ys[6:0], s1 ? d1 : d0};
      ss = {ss[6:0], s1};
      if (change_mid && i == 2) begin
        a = 4'b0000;
        b = 4'b0000;
      end
      @(negedge clk);
    end
    chk({nm, "_y"}, 30'(ys), 30'(8'b10011100));
    chk({nm, "_s1"}, 30'(ss), 30'(8'b01010101));
    chk({nm, "_fin"}, 30'(out4()), 30'(6'b000010));
    @(negedge clk);
    chk({nm, "_ready"}, 30'(out4()), 30'(IDLE_O));
  endtask
  initial begin
    rst = 1'b1;
    #1;
    chk("rst_w4", 30'(out4()), 30'(IDLE_O));
    chk("rst_w1", 30'(out1()), 30'(IDLE_O));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", 30'(out4()), 30'(IDLE_O));
    run_s2("s2", 1'b0);
    @(negedge clk);
    run_s2("s3", 1'b1);
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0000;
    start = 1'b1;
    dmask = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      dmask[i] = dn;
    end
    start = 1'b0;
    chk("s4_done_pos", dmask, 30'(1) << 8 | 30'(1) << 18 | 30'(1) << 28);
    repeat (2) @(negedge clk);
    a = 4'b1010;
    b = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_mid_valid", 30'(vld), 30'(1));
    #1 rst = 1'b1;
    #1;
    chk("s5_async_rst", 30'(out4()), 30'(IDLE_O));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("s5_no_done", 30'(out4()), 30'(IDLE_O));
    run_s2("s5_rerun", 1'b0);
    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s6_e1", 30'({s1_1, s1_1 ? d1_1 : d0_1}), 30'(2'b01));
    @(negedge clk);
    chk("s6_e2", 30'({s1_1, s1_1 ? d1_1 : d0_1}), 30'(2'b10));
    @(negedge clk);
    chk("s6_done", 30'(out1()), 30'(6'b000010));
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
